// File: rtl/store_buffer.sv
// Word-wide store buffer between the MEM stage and a single-port data memory.
// Loads own the memory port and forward from the youngest buffered store; stores drain when the port is free.
module store_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        memread_i,
  input  logic        memwrite_i,
  input  logic [31:0] memaddr_i,
  input  logic [31:0] writedata_i,
  output logic [31:0] memdata_o,
  output logic        stall_o,
  output logic        empty_o,
  output logic        dm_memread_o,
  output logic        dm_memwrite_o,
  output logic [31:0] dm_addr_o,
  output logic [31:0] dm_writedata_o,
  input  logic [31:0] dm_rdata_i
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [31:0]   addr_q [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic          empty;
  logic          full;
  logic          drain;
  logic          push;
  logic          fwd_hit;
  logic [31:0]   fwd_data;
  logic [AW-1:0] idx;

  always_comb begin
    empty          = (count == '0);
    full           = (count == CW'(DEPTH));
    drain          = !rst_i && !memread_i && !empty;
    stall_o        = !rst_i && memwrite_i && full && !drain;
    push           = !rst_i && memwrite_i && !stall_o;
    dm_memread_o   = !rst_i && memread_i;
    dm_memwrite_o  = drain;
    dm_addr_o      = '0;
    dm_writedata_o = '0;
    if (dm_memread_o) begin
      dm_addr_o = memaddr_i;
    end else if (drain) begin
      dm_addr_o      = addr_q[rd_ptr];
      dm_writedata_o = data_q[rd_ptr];
    end
    empty_o = empty;
  end

  // Walk oldest to youngest so the last match left standing is the youngest store.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + AW'(i);
      if ((CW'(i) < count) && (addr_q[idx] == memaddr_i)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[idx];
      end
    end
    if (!memread_i)   memdata_o = '0;
    else if (fwd_hit) memdata_o = fwd_data;
    else              memdata_o = dm_rdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + AW'(1);
      if (drain) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(drain);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      addr_q[wr_ptr] <= memaddr_i;
      data_q[wr_ptr] <= writedata_i;
    end
  end

endmodule

// File: doc/store_buffer.md
# store_buffer

Word-wide store buffer between the MEM pipeline stage and the single-port `Data_Memory`. Stores from the pipeline are queued and drained to memory whenever the memory port is free, so stores never cost a cycle unless the buffer is full and a load owns the port. Loads have priority on the memory port and are forwarded from the youngest matching buffered store, giving memory-consistent read data with zero added latency. `empty_o` lets the control unit wait for a full drain, for example before halting.

## Interface
- `DEPTH`, 4: number of entries; must be a power of two and at least 2.
- `clk_i`  in  1  Clock; all state updates on the rising edge.
- `rst_i`  in  1  Reset, synchronous, active-high.
- `memread_i`  in  1  Load request from the MEM stage.
- `memwrite_i`  in  1  Store request from the MEM stage.
- `memaddr_i`  in  32  Load/store address, word granularity, full 32-bit compare.
- `writedata_i`  in  32  Store data.
- `memdata_o`  out  32  Load data to MEM/WB.
- `stall_o`  out  1  Store not accepted this cycle; the pipeline must hold and re-present it.
- `empty_o`  out  1  Buffer holds no entries.
- `dm_memread_o`  out  1  To `Data_Memory` `memread_i`.
- `dm_memwrite_o`  out  1  To `Data_Memory` `memwrite_i`.
- `dm_addr_o`  out  32  To `Data_Memory` `memaddr_i`.
- `dm_writedata_o`  out  32  To `Data_Memory` `writedata_i`.
- `dm_rdata_i`  in  32  From `Data_Memory` `memdata_o`; combinational read.

## Operation
- **State:** circular FIFO with `DEPTH` entries. Each entry holds {addr[31:0], data[31:0]}.
  - Read and write pointers are each log2(DEPTH) bits and wrap modulo `DEPTH`.
  - `count` is log2(DEPTH)+1 bits; full = (count == DEPTH); empty = (count == 0).
- **Port arbitration, per cycle:**
  - Load (`memread_i`=1): `dm_memread_o`=1, `dm_addr_o`=`memaddr_i`, `dm_memwrite_o`=0. No drain this cycle.
  - Otherwise, drain = !empty: `dm_memwrite_o`=1, `dm_addr_o`/`dm_writedata_o` = head entry, `dm_memread_o`=0. The head is popped at the edge.
  - Idle (no load, empty): all `dm_*` outputs are 0.
- **Store acceptance:** push = `memwrite_i` & !`stall_o`.
  - `stall_o` = `memwrite_i` & full & !drain. With drain active, a push and a pop happen in the same cycle and `count` is unchanged.
  - Push writes {`memaddr_i`, `writedata_i`} at the write pointer and advances it.
- **Load forwarding:**
  - When `memread_i`=1, compare `memaddr_i` against every valid entry.
  - On a hit, `memdata_o` = data of the youngest matching entry (closest to the write pointer).
  - On a miss, `memdata_o` = `dm_rdata_i`.
  - When `memread_i`=0, `memdata_o` = 0.
- **Simultaneous load and store:** legal. The load is served first and sees only contents present before the edge; the store is pushed at the same edge if not stalled.
- **Ordering:** stores drain strictly in FIFO order. Repeated stores to one address are not merged.
- **Reset:**
  - Pointers and `count` are cleared. Entry payloads are don't-care.
  - While `rst_i`=1, `stall_o`, `dm_memread_o` and `dm_memwrite_o` are forced to 0, and no push or pop occurs.
  - After reset: `empty_o`=1, `memdata_o`=0, `dm_addr_o`=0, `dm_writedata_o`=0.
  - Reset mid-operation discards buffered stores; they never reach memory.

## Timing
- Load data is combinational, with zero cycles of added latency. The path is `memaddr_i` → compare → mux → `memdata_o`, in parallel with the `Data_Memory` read.
- `stall_o` and all `dm_*` outputs are combinational from inputs and current state; they are not registered.
- A store pushed at edge N:
  - is forwardable from cycle N+1;
  - is written to memory no earlier than cycle N+1;
  - drains in the first cycle at or after N+1 in which it is the head and `memread_i`=0.
- Throughput: one push and one pop per cycle.
- Worst case: continuous loads starve draining indefinitely. Stores stall only when the buffer is full during a load.
- `empty_o` reflects registered `count` and updates the cycle after the final pop.

## Test plan
- **Reset:** hold `rst_i` 2 cycles with `memwrite_i`=1 → `empty_o`=1, `stall_o`=0, `dm_memwrite_o`=0, nothing pushed.
- **Drain:** single store (0x10, 0xDEADBEEF), then idle → the next cycle shows `dm_memwrite_o`=1, `dm_addr_o`=0x10, `dm_writedata_o`=0xDEADBEEF; `empty_o`=1 the cycle after.
- **Forwarding, youngest wins:**
  - Hold `memread_i`=1 (address 0x20) to block draining.
  - Push (0x20, 1) then (0x20, 2) → load of 0x20 returns 2.
  - Load of 0x24 returns `dm_rdata_i`.
- **Full plus load:** hold `memread_i`=1 and issue 5 stores with `DEPTH`=4 → `stall_o`=1 on the 5th only. Drop `memread_i` → the 5th is accepted that cycle and the head drains, with `count` staying 4.
- **FIFO ordering and wrap:** 10 stores to addresses 0..9 with interleaved loads → the `dm_memwrite_o` sequence has addresses 0..9 in order, and the final memory contents match a reference model.
- **Reset mid-operation:** assert `rst_i` with 3 entries buffered → no further `dm_memwrite_o`; `empty_o`=1 after the reset edge.
